sync_handshake_core: RTL and testbench
======================================

# sync_handshake_core

Single-clock pulse-plus-data handshake transfer block: a source-side strobe with a DATA_WIDTH payload is carried to a destination-side register through a toggle request/acknowledge loop. Each direction of the loop has SYNC_STAGE register stages. The block sits between a producer that issues sparse update strobes and a consumer register. `sync_busy` back-pressures the producer until the previous transfer has been acknowledged.

## Interface
Parameters:
- `SYNC_STAGE`, default 2: register stages in each direction of the req/ack loop; legal range ≥2.
- `DATA_WIDTH`, default 8: payload width.

Ports:
- `clk`, input, 1: the single clock; all logic is rising-edge.
- `rst_n`, input, 1: reset; one clock; reset is asynchronous and active-low.
- `sig_pulse_source`, input, 1: transfer strobe, sampled each edge.
- `sig_data_source`, input, DATA_WIDTH: payload, captured with an accepted strobe.
- `sig_data_dest`, output, DATA_WIDTH: delivered payload, held until the next delivery.
- `sig_pulse_dest`, output, 1: one-cycle strobe coincident with each `sig_data_dest` update.
- `sync_busy`, output, 1: transfer in flight; new strobes are not accepted while high.

## Operation
- Accept condition: `sig_pulse_source && !sync_busy` at a rising edge.
- On accept:
  - `sig_data_source` is latched into an internal hold register.
  - The source request flag `req` toggles.
- Strobes arriving while `sync_busy` is high are dropped. The hold register and `req` are unchanged.
- Request path:
  - `req` shifts through a SYNC_STAGE-deep register chain.
  - The destination keeps `req_seen`, the chain output delayed one more register.
  - When chain output ≠ `req_seen`, the destination loads `sig_data_dest` from the hold register and pulses `sig_pulse_dest` on the next edge.
- Acknowledge path:
  - `req_seen` acts as `ack`.
  - `ack` shifts through a SYNC_STAGE-deep chain back to the source, producing `ack_sync`.
- `sync_busy = req ^ ack_sync`, a combinational XOR of registers with no glitch-prone inputs.
- The hold register is stable from acceptance until `ack_sync` returns, so the destination never samples a changing payload.
- Reset (asynchronous assert, any time, including mid-transfer):
  - All registers clear to 0, including `req`, both chains, `req_seen`, the hold register, `sig_data_dest`, `sig_pulse_dest`, and the drop counter.
  - Any in-flight transfer is discarded; no spurious `sig_pulse_dest` occurs after release.
  - `sync_busy` is 0 while in reset and on release.

## Timing
Let acceptance occur at edge k, with S = SYNC_STAGE.
- `req` toggles at edge k; `sync_busy` is high after edge k.
- `sig_pulse_dest` is high for exactly the cycle after edge k+S+1; `sig_data_dest` updates at edge k+S+1. Latency is S+1 cycles.
- `ack_sync` matches `req` at edge k+2S+1, and `sync_busy` falls after that edge.
- The earliest next acceptance is edge k+2S+2. Peak throughput is one transfer per 2S+2 cycles (6 cycles for S=2).
- A strobe held high across many cycles yields one transfer per 2S+2 cycles. The payload is sampled at each accepting edge.
- A strobe and `sync_busy` falling in the same cycle: the strobe is accepted only at an edge where `sync_busy` is already low.

## Configuration
- Macro `SYNC_HANDSHAKE_DROP_CNT_EN`.
- Defined:
  - Adds output `drop_cnt`, 8 bits, reset 0.
  - Increments at each edge where `sig_pulse_source && sync_busy`.
  - Saturates at 255.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, release → all outputs 0, `sync_busy`=0, no `sig_pulse_dest` for 20 cycles.
- Single transfer, S=2: strobe with data 0xA5 accepted at edge k → `sig_data_dest`=0xA5 with `sig_pulse_dest` high after edge k+3; `sync_busy` high from edge k through edge k+5.
- Back-pressure:
  - Strobe with 0xA5 accepted at edge k, then strobe with 0x3C at edge k+2 → 0x3C dropped; `sig_data_dest` stays 0xA5.
  - With the macro defined, `drop_cnt`=1.
- Back-to-back: `sig_pulse_source` held high for 20 cycles with incrementing data → accepts at k, k+6, k+12, k+18; each delivered value equals the data present at its accepting edge.
- Mid-transfer reset: assert `rst_n` at edge k+2 after accepting 0x5A → `sig_data_dest` stays 0 and no `sig_pulse_dest` appears; the next transfer of 0x11 completes normally.
- Parameter sweep: S=3, DATA_WIDTH=16, data 0xBEEF → delivery at k+4, `sync_busy` low after edge k+7.

Source files
------------

// File: rtl/sync_handshake_core.sv
// sync_handshake_core
// Carries a source-side strobe plus DATA_WIDTH payload to a destination
// register through a toggle request/acknowledge loop. Each direction of the
// loop is SYNC_STAGE registers deep (SYNC_STAGE must be 2 or more).
// sync_busy stays high from an accepted strobe until the acknowledge toggle
// has travelled back to the source, so only one transfer is in flight.
//
// Optional feature: define SYNC_HANDSHAKE_DROP_CNT_EN to add an 8-bit
// saturating drop_cnt output. It counts strobes rejected while busy.
module sync_handshake_core #(
  parameter int SYNC_STAGE = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sig_pulse_source,
  input  logic [DATA_WIDTH-1:0] sig_data_source,
  output logic [DATA_WIDTH-1:0] sig_data_dest,
  output logic                  sig_pulse_dest,
  output logic                  sync_busy
`ifdef SYNC_HANDSHAKE_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  // ---------------------------------------------------------------------
  // Source side
  // ---------------------------------------------------------------------
  logic                  req_reg;
  logic                  req_next;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [DATA_WIDTH-1:0] hold_next;
  logic                  accept;
  logic                  ack_sync;

  // Request and acknowledge chains, plus the inputs of each stage.
  logic [SYNC_STAGE-1:0] req_chain_reg;
  logic [SYNC_STAGE-1:0] req_chain_next;
  logic [SYNC_STAGE-1:0] ack_chain_reg;
  logic [SYNC_STAGE-1:0] ack_chain_next;

  // Destination side
  logic                  req_out;
  logic                  req_seen_reg;
  logic                  new_req;
  logic [DATA_WIDTH-1:0] data_dest_reg;
  logic [DATA_WIDTH-1:0] data_dest_next;
  logic                  pulse_dest_reg;

  // Busy is a pure XOR of two registers, so it cannot glitch on inputs.
  assign ack_sync  = ack_chain_reg[SYNC_STAGE-1];
  assign sync_busy = req_reg ^ ack_sync;

  // A strobe is taken only when no transfer is outstanding at this edge.
  assign accept    = sig_pulse_source & ~sync_busy;
  assign req_next  = req_reg ^ accept;
  assign hold_next = accept ? sig_data_source : hold_reg;

  // Source request toggle and payload hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_reg  <= 1'b0;
      hold_reg <= '0;
    end else begin
      req_reg  <= req_next;
      hold_reg <= hold_next;
    end
  end

  // ---------------------------------------------------------------------
  // Chain stage wiring: stage 0 takes the loop input, each later stage
  // takes the previous stage's output.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGE; gi++) begin : g_chain
      if (gi == 0) begin : g_first
        assign req_chain_next[gi] = req_reg;
        assign ack_chain_next[gi] = req_seen_reg;
      end else begin : g_rest
        assign req_chain_next[gi] = req_chain_reg[gi-1];
        assign ack_chain_next[gi] = ack_chain_reg[gi-1];
      end
    end
  endgenerate

  // Request chain: source toggle travelling toward the destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_chain_reg <= '0;
    end else begin
      req_chain_reg <= req_chain_next;
    end
  end

  // Acknowledge chain: req_seen travelling back toward the source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_chain_reg <= '0;
    end else begin
      ack_chain_reg <= ack_chain_next;
    end
  end

  // ---------------------------------------------------------------------
  // Destination side
  // ---------------------------------------------------------------------
  // A difference between the chain output and its delayed copy marks the
  // arrival of a new request toggle. The hold register has been stable since
  // acceptance, so sampling it here is safe.
  assign req_out        = req_chain_reg[SYNC_STAGE-1];
  assign new_req        = req_out ^ req_seen_reg;
  assign data_dest_next = new_req ? hold_reg : data_dest_reg;

  // Edge detector state, delivered payload and the delivery strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_seen_reg   <= 1'b0;
      data_dest_reg  <= '0;
      pulse_dest_reg <= 1'b0;
    end else begin
      req_seen_reg   <= req_out;
      data_dest_reg  <= data_dest_next;
      pulse_dest_reg <= new_req;
    end
  end

  assign sig_data_dest  = data_dest_reg;
  assign sig_pulse_dest = pulse_dest_reg;

`ifdef SYNC_HANDSHAKE_DROP_CNT_EN
  // ---------------------------------------------------------------------
  // Drop counter: strobes that arrive while a transfer is in flight.
  // ---------------------------------------------------------------------
  logic [7:0] drop_cnt_reg;
  logic [7:0] drop_cnt_next;

  // Saturate at 255 rather than wrapping so a long overload stays visible.
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (sig_pulse_source && sync_busy && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_next = drop_cnt_reg + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg <= 8'd0;
    end else begin
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_sync_handshake_core.sv
// Directed bench for sync_handshake_core: a default instance (S=2, 8-bit)
// and a second instance (S=3, 16-bit) share clock and reset.
module tb_sync_handshake_core;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        p0;
  logic [7:0]  d0;
  logic [7:0]  dd0;
  logic        pd0;
  logic        b0;
  logic        p1;
  logic [15:0] d1;
  logic [15:0] dd1;
  logic        pd1;
  logic        b1;
`ifdef SYNC_HANDSHAKE_DROP_CNT_EN
  logic [7:0]  dc0;
  logic [7:0]  dc1;
`endif

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  sync_handshake_core #(.SYNC_STAGE(2), .DATA_WIDTH(8)) u_dut0 (
    .clk              (clk),
    .rst_n            (rst_n),
    .sig_pulse_source (p0),
    .sig_data_source  (d0),
    .sig_data_dest    (dd0),
    .sig_pulse_dest   (pd0),
    .sync_busy        (b0)
`ifdef SYNC_HANDSHAKE_DROP_CNT_EN
    ,
    .drop_cnt         (dc0)
`endif
  );

  sync_handshake_core #(.SYNC_STAGE(3), .DATA_WIDTH(16)) u_dut1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .sig_pulse_source (p1),
    .sig_data_source  (d1),
    .sig_data_dest    (dd1),
    .sig_pulse_dest   (pd1),
    .sync_busy        (b1)
`ifdef SYNC_HANDSHAKE_DROP_CNT_EN
    ,
    .drop_cnt         (dc1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          npulse;
  int          nbusy;
  int          nrec;
  int          rec_cyc [8];
  logic [7:0]  rec_val [8];

  initial begin
    rst_n = 1'b1;
    p0 = 1'b0; d0 = '0;
    p1 = 1'b0; d1 = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_busy", {31'd0, b0}, 32'd0);
    chk("rst_async_pulse", {31'd0, pd0}, 32'd0);
    chk("rst_async_data", {24'd0, dd0}, 32'd0);
    repeat (3) tick();
    chk("rst_hold_busy", {31'd0, b0}, 32'd0);
    chk("rst_hold_data", {24'd0, dd0}, 32'd0);
    rst_n = 1'b1;
    npulse = 0; nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pd0) npulse++;
      if (b0) nbusy++;
    end
    chk("rst_idle_pulses", npulse, 32'd0);
    chk("rst_idle_busy", nbusy, 32'd0);
    chk("rst_idle_data", {24'd0, dd0}, 32'd0);
`ifdef SYNC_HANDSHAKE_DROP_CNT_EN
    chk("rst_drop_cnt", {24'd0, dc0}, 32'd0);
`endif
    $display("reset: idle 20 cycles, pulses=%0d busy_cycles=%0d", npulse, nbusy);

    // Single transfer, S=2.
    p0 = 1'b1; d0 = 8'hA5;
    tick();                                   // edge k
    p0 = 1'b0; d0 = 8'h00;
    chk("single_busy_k", {31'd0, b0}, 32'd1);
    chk("single_pulse_k", {31'd0, pd0}, 32'd0);
    tick();                                   // k+1
    chk("single_busy_k1", {31'd0, b0}, 32'd1);
    chk("single_pulse_k1", {31'd0, pd0}, 32'd0);
    tick();                                   // k+2
    chk("single_pulse_k2", {31'd0, pd0}, 32'd0);
    chk("single_data_k2", {24'd0, dd0}, 32'd0);
    tick();                                   // k+3
    chk("single_pulse_k3", {31'd0, pd0}, 32'd1);
    chk("single_data_k3", {24'd0, dd0}, 32'hA5);
    tick();                                   // k+4
    chk("single_pulse_k4", {31'd0, pd0}, 32'd0);
    chk("single_busy_k4", {31'd0, b0}, 32'd1);
    tick();                                   // k+5
    chk("single_busy_k5", {31'd0, b0}, 32'd0);
    chk("single_data_k5", {24'd0, dd0}, 32'hA5);
    $display("single: delivered 0x%0h", dd0);

    // Back-pressure: second strobe at k+2 is dropped.
    p0 = 1'b1; d0 = 8'hA5;
    tick();                                   // k
    p0 = 1'b0;
    tick();                                   // k+1
    p0 = 1'b1; d0 = 8'h3C;
    tick();                                   // k+2, dropped
    p0 = 1'b0; d0 = 8'h00;
    chk("bp_busy_k2", {31'd0, b0}, 32'd1);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pd0) npulse++;
    end
    chk("bp_pulses", npulse, 32'd1);
    chk("bp_data", {24'd0, dd0}, 32'hA5);
    chk("bp_busy_end", {31'd0, b0}, 32'd0);
`ifdef SYNC_HANDSHAKE_DROP_CNT_EN
    chk("bp_drop_cnt", {24'd0, dc0}, 32'd1);
`endif
    $display("backpressure: pulses=%0d data=0x%0h", npulse, dd0);

    // Back-to-back: strobe held for 20 edges with incrementing data.
    nrec = 0;
    for (int j = 0; j < 8; j++) begin
      rec_cyc[j] = -1;
      rec_val[j] = 8'hFF;
    end
    p0 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) p0 = 1'b0;
      d0 = 8'h10 + 8'(i);
      tick();
      if (pd0) begin
        if (nrec < 8) begin
          rec_cyc[nrec] = i;
          rec_val[nrec] = dd0;
        end
        nrec++;
      end
    end
    d0 = 8'h00;
    chk("b2b_count", nrec, 32'd4);
    chk("b2b_cyc0", rec_cyc[0], 32'd3);
    chk("b2b_val0", {24'd0, rec_val[0]}, 32'h10);
    chk("b2b_cyc1", rec_cyc[1], 32'd9);
    chk("b2b_val1", {24'd0, rec_val[1]}, 32'h16);
    chk("b2b_cyc2", rec_cyc[2], 32'd15);
    chk("b2b_val2", {24'd0, rec_val[2]}, 32'h1C);
    chk("b2b_cyc3", rec_cyc[3], 32'd21);
    chk("b2b_val3", {24'd0, rec_val[3]}, 32'h22);
`ifdef SYNC_HANDSHAKE_DROP_CNT_EN
    chk("b2b_drop_cnt", {24'd0, dc0}, 32'd17);
`endif
    $display("back2back: deliveries=%0d last=0x%0h", nrec, dd0);

    // Mid-transfer reset.
    p0 = 1'b1; d0 = 8'h5A;
    tick();                                   // k
    p0 = 1'b0; d0 = 8'h00;
    tick();                                   // k+1
    tick();                                   // k+2
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, b0}, 32'd0);
    chk("midrst_data", {24'd0, dd0}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    npulse = 0; nbusy = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (pd0) npulse++;
      if (b0) nbusy++;
    end
    chk("midrst_pulses", npulse, 32'd0);
    chk("midrst_busy_cycles", nbusy, 32'd0);
    chk("midrst_data_after", {24'd0, dd0}, 32'd0);
`ifdef SYNC_HANDSHAKE_DROP_CNT_EN
    chk("midrst_drop_cnt", {24'd0, dc0}, 32'd0);
`endif
    p0 = 1'b1; d0 = 8'h11;
    tick();                                   // k
    p0 = 1'b0; d0 = 8'h00;
    tick();
    tick();
    tick();                                   // k+3
    chk("post_rst_pulse", {31'd0, pd0}, 32'd1);
    chk("post_rst_data", {24'd0, dd0}, 32'h11);
    tick();
    tick();                                   // k+5
    chk("post_rst_busy", {31'd0, b0}, 32'd0);
    $display("midreset: spurious pulses=%0d, next transfer 0x%0h", npulse, dd0);

    // Second instance: S=3, 16-bit payload.
    p1 = 1'b1; d1 = 16'hBEEF;
    tick();                                   // k
    p1 = 1'b0; d1 = 16'h0000;
    chk("s3_busy_k", {31'd0, b1}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();                                 // k+1..k+3
      chk("s3_pulse_early", {31'd0, pd1}, 32'd0);
    end
    tick();                                   // k+4
    chk("s3_pulse_k4", {31'd0, pd1}, 32'd1);
    chk("s3_data_k4", {16'd0, dd1}, 32'hBEEF);
    tick();                                   // k+5
    chk("s3_pulse_k5", {31'd0, pd1}, 32'd0);
    tick();                                   // k+6
    chk("s3_busy_k6", {31'd0, b1}, 32'd1);
    tick();                                   // k+7
    chk("s3_busy_k7", {31'd0, b1}, 32'd0);
    $display("s3: delivered 0x%0h", dd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
